key_onehot_capture: RTL and testbench
=====================================

// Module: key_onehot_capture
// PURPOSE
//   Front end for the 8:3 encoder. Takes 8 raw active-low push-buttons,
//   synchronises and debounces them, and outputs a registered one-hot code.
//   key_onehot feeds the encoder's 8-bit input directly.
//   key_valid strobes once per accepted press; key_err flags multi-key presses.
// PARAMETERS
//   DB_CNT  1000  stable cycles required to accept a press or a release (>=2)
//   CNT_W   10    debounce counter width; must satisfy 2**CNT_W >= DB_CNT
// PORTS
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   key_n       in   8  raw buttons, 0 = pressed, asynchronous to clk
//   key_onehot  out  8  last accepted key, one-hot; 8'h00 until first accept
//   key_valid   out  1  1-cycle pulse when key_onehot is updated
//   key_err     out  1  1-cycle pulse when a debounced press is not one-hot
//   busy        out  1  high in every state except IDLE
// BEHAVIOUR
//   Reset (async assert, sync release): sync flops = 8'hFF, state = IDLE,
//     cnt = 0, cand = 0, key_onehot = 0, key_valid = 0, key_err = 0, busy = 0.
//   Sync: 2-flop synchroniser per bit. p = ~sync2 (1 = pressed).
//   FSM, one transition per clk:
//     IDLE:       p != 0 -> cand <= p, cnt <= 0, go to PRESS_DB.
//     PRESS_DB:   p != cand -> IDLE, cnt <= 0 (bounce; nothing reported).
//                 Else if cnt == DB_CNT-1 -> HELD:
//                   cand one-hot: key_onehot <= cand, key_valid = 1.
//                   cand not one-hot: key_err = 1, key_onehot unchanged.
//                 Else cnt <= cnt + 1.
//     HELD:       p == 0 -> RELEASE_DB, cnt <= 0. Any other change of p
//                 (extra key, key swap) is ignored until full release.
//     RELEASE_DB: p != 0 -> HELD (release bounce). Else if cnt == DB_CNT-1
//                 -> IDLE. Else cnt <= cnt + 1.
//   key_valid/key_err: registered, high for exactly the cycle after the
//     accepting edge. Never both high. At most one per press/release cycle.
//   key_onehot: registered; holds its value across releases, bounces and errors.
//     Changes only together with key_valid. Always 0 or exactly one bit set.
//   Latency: with key_n stable from the edge that first samples it (edge 1),
//     key_valid is high after edge DB_CNT+3.
//   Counter never wraps: it is cleared on every state entry and saturates at
//     DB_CNT-1 by construction.
//   Reset mid-debounce: all state is discarded. A key still held after
//     rst_n rises is re-debounced from IDLE and reported again.
//   Unknown state encodings recover to IDLE.
// TESTING  (DB_CNT=4)
//   1. Reset, key_n=8'hFF for 20 cycles -> key_onehot=8'h00, no pulses,
//      busy=0.
//   2. key_n=8'hFE held -> exactly one key_valid, 7 edges after change;
//      key_onehot=8'h01. Then release -> busy falls 4+3 edges later,
//      key_onehot stays 8'h01.
//   3. key_n toggles 8'hDF/8'hFF every 2 cycles for 20 cycles, then holds
//      8'hDF -> single key_valid, key_onehot=8'h20, no pulse during bouncing.
//   4. key_n=8'hFC held -> one key_err pulse, key_onehot keeps its prior
//      value, no key_valid.
//   5. Hold 8'h7F until accepted (key_onehot=8'h80), then press a second key
//      (8'h7E) -> no new pulse. Release all, then press 8'hF7 ->
//      key_onehot=8'h08. Encoder output follows 3'b111 then 3'b011.
//   6. rst_n low for 1 cycle in PRESS_DB with 8'hEF held -> outputs clear
//      immediately; after release of reset, one key_valid with key_onehot=8'h10.

Source files
------------

// File: rtl/key_onehot_capture.sv
// Button front end for the 8:3 encoder: per-key 2-flop synchroniser, then a
// debounce FSM that reports one-hot presses (key_valid) or multi-key chords (key_err).

module key_sync_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1;

  // Idle level of an active-low button is 1, so reset to "released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

module key_onehot_capture #(
  parameter int DB_CNT = 1000,
  parameter int CNT_W  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key_n,
  output logic [7:0] key_onehot,
  output logic       key_valid,
  output logic       key_err,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CNT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       cand;
  logic [7:0]       sync2;
  logic [7:0]       p;
  logic             cand_onehot;

  for (genvar i = 0; i < 8; i++) begin : g_sync
    key_sync_bit u_sync (.clk(clk), .rst_n(rst_n), .d(key_n[i]), .q(sync2[i]));
  end

  assign p           = ~sync2;
  assign cand_onehot = (cand != 8'h00) && ((cand & (cand - 8'h01)) == 8'h00);

  // busy mirrors state != IDLE but is registered alongside the state update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cand       <= 8'h00;
      key_onehot <= 8'h00;
      key_valid  <= 1'b0;
      key_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (p != 8'h00) begin
            cand  <= p;
            cnt   <= '0;
            state <= PRESS_DB;
            busy  <= 1'b1;
          end
        end
        PRESS_DB: begin
          if (p != cand) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == LAST) begin
            cnt   <= '0;
            state <= HELD;
            if (cand_onehot) begin
              key_onehot <= cand;
              key_valid  <= 1'b1;
            end else begin
              key_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          // Extra keys or swaps while held are ignored until a full release.
          if (p == 8'h00) begin
            cnt   <= '0;
            state <= RELEASE_DB;
          end
        end
        RELEASE_DB: begin
          if (p != 8'h00) begin
            cnt   <= '0;
            state <= HELD;
          end else if (cnt == LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_key_onehot_capture.sv
// Scoreboard bench for key_onehot_capture at DB_CNT=4: stimulus queues expected
// pulses, a negedge monitor pops and compares every key_valid/key_err pulse.

module tb_key_onehot_capture;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] key_n;
  logic [7:0] key_onehot;
  logic       key_valid, key_err, busy;

  typedef struct {
    logic       err;
    logic [7:0] oh;
    int         cyc;   // negative: timing not checked
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  key_onehot_capture #(.DB_CNT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n),
    .key_onehot(key_onehot), .key_valid(key_valid), .key_err(key_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] enc83(input logic [7:0] oh);
    logic [2:0] r = 3'd0;
    for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic err, input logic [7:0] oh, input int dcyc);
    exp_t e;
    e.err = err; e.oh = oh; e.cyc = (dcyc < 0) ? -1 : cyc + dcyc;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (key_valid || key_err)) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b onehot=%0h at cycle %0d",
                 key_valid, key_err, key_onehot, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind_valid", {31'd0, key_valid}, {31'd0, ~e.err});
        chk("pulse_kind_err", {31'd0, key_err}, {31'd0, e.err});
        chk("pulse_onehot", {24'd0, key_onehot}, {24'd0, e.oh});
        if (e.cyc >= 0) chk("pulse_latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    key_n = 8'hFF;
    step(3);
    chk("rst_onehot", {24'd0, key_onehot}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_pulses", {30'd0, key_valid, key_err}, 32'h0);
    rst_n = 1'b1;

    // 1: idle keys, nothing happens
    step(20);
    chk("idle_onehot", {24'd0, key_onehot}, 32'h0);
    chk("idle_busy", {31'd0, busy}, 32'h0);

    // 2: clean press of key 0, exact latency, then release timing
    key_n = 8'hFE;
    expect_pulse(1'b0, 8'h01, 7);
    step(10);
    chk("t2_onehot", {24'd0, key_onehot}, 32'h01);
    chk("t2_busy_held", {31'd0, busy}, 32'h1);
    key_n = 8'hFF;
    step(6);
    chk("t2_busy_before_fall", {31'd0, busy}, 32'h1);
    step(1);
    chk("t2_busy_fell", {31'd0, busy}, 32'h0);
    chk("t2_onehot_kept", {24'd0, key_onehot}, 32'h01);

    // 3: bouncing key 5, then stable
    for (int i = 0; i < 5; i++) begin
      key_n = 8'hDF; step(2);
      key_n = 8'hFF; step(2);
    end
    chk("t3_no_accept_bounce", {24'd0, key_onehot}, 32'h01);
    key_n = 8'hDF;
    expect_pulse(1'b0, 8'h20, 7);
    step(12);
    chk("t3_onehot", {24'd0, key_onehot}, 32'h20);
    key_n = 8'hFF;
    step(10);

    // 4: two keys at once -> error, value kept
    key_n = 8'hFC;
    expect_pulse(1'b1, 8'h20, 7);
    step(12);
    chk("t4_onehot_kept", {24'd0, key_onehot}, 32'h20);
    key_n = 8'hFF;
    step(10);
    chk("t4_busy_idle", {31'd0, busy}, 32'h0);

    // 5: key 7, extra key ignored while held, then key 3
    key_n = 8'h7F;
    expect_pulse(1'b0, 8'h80, 7);
    step(10);
    chk("t5_onehot_k7", {24'd0, key_onehot}, 32'h80);
    chk("t5_enc_k7", {29'd0, enc83(key_onehot)}, 32'h7);
    key_n = 8'h7E;
    step(10);
    chk("t5_extra_ignored", {24'd0, key_onehot}, 32'h80);
    key_n = 8'hFF;
    step(10);
    key_n = 8'hF7;
    expect_pulse(1'b0, 8'h08, 7);
    step(10);
    chk("t5_onehot_k3", {24'd0, key_onehot}, 32'h08);
    chk("t5_enc_k3", {29'd0, enc83(key_onehot)}, 32'h3);
    key_n = 8'hFF;
    step(10);

    // 6: reset during PRESS_DB, key re-debounced afterwards
    key_n = 8'hEF;
    step(4);
    chk("t6_busy_in_db", {31'd0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_onehot", {24'd0, key_onehot}, 32'h0);
    chk("t6_rst_busy", {31'd0, busy}, 32'h0);
    step(1);
    rst_n = 1'b1;
    expect_pulse(1'b0, 8'h10, 7);
    step(10);
    chk("t6_onehot", {24'd0, key_onehot}, 32'h10);
    key_n = 8'hFF;
    step(10);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
